ascon_perm_engine: RTL and testbench
====================================

// Module: ascon_perm_engine
// PURPOSE
//  Parametrised, handshaked Ascon permutation engine computing p^nr (nr = 0..12) on a 320-bit state.
//  UNROLL round instances are chained combinationally; the engine iterates over ceil(nr/UNROLL) cycles.
//  Sits between the mode controller (init/AD/text/finalise) and the state register file.
//  Replaces the fixed p8/p12 iterators: any round count, valid/ready handshakes, backpressure, abort.
// PARAMETERS
//  UNROLL   4   rounds per cycle; legal values 1,2,3,4,6,12 (other values: $error at elaboration)
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   request valid
//  in_ready   out  1   engine can accept a request (state IDLE)
//  nr         in   4   number of rounds; values 13..15 treated as 12
//  x0_i..x4_i in   64  input state words (x0 = S[0..63] per spec word order)
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer takes result
//  x0_o..x4_o out  64  result words; 0 whenever out_valid = 0
//  abort      in   1   synchronous flush, highest priority after reset
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Round function, applied per round index r in 0..11:
//   - x2 ^= {56'h0, ~r[3:0], r[3:0]}  (f0,e1,d2,c3,b4,a5,96,87,78,69,5a,4b)
//   - 5-bit Ascon S-box bit-sliced across the five words
//   - linear layer (rotate right): x0 19/28, x1 61/39, x2 1/6, x3 10/17, x4 7/41
//  Schedule: p^nr applies indices 12-nr .. 11 in ascending order.
//  Slot j of a cycle uses index idx+j. Slots with idx+j > 11 are bypassed (output = input, no constant),
//   so nr need not be a multiple of UNROLL.
//  Registers:
//   - st[319:0]  working state
//   - idx[3:0]   next round index to apply
//   - FSM        IDLE / RUN / DONE
//  IDLE:
//   - in_ready = 1
//   - on in_valid: st <= UNROLL rounds applied to x*_i starting at idx0 = 12 - nr, and idx <= idx0 + UNROLL
//   - if idx0 + UNROLL >= 12, go to DONE; otherwise go to RUN
//   - nr = 0: st <= x*_i unchanged, go to DONE
//  RUN:
//   - each cycle: st <= UNROLL rounds applied to st, idx <= idx + UNROLL
//   - go to DONE when idx + UNROLL >= 12
//   - in_ready = 0; in_valid is ignored
//  DONE:
//   - out_valid = 1; x*_o = st, held stable until taken
//   - out_ready = 1: go to IDLE next cycle
//   - no same-cycle re-accept: in_ready rises one cycle after the take
//  Latency: out_valid rises max(1, ceil(nr/UNROLL)) clock edges after the accept edge.
//   Throughput is one request per latency + 1 cycles.
//  Request fields are sampled only at the accept edge; later changes to x*_i or nr have no effect.
//  abort = 1 in any state: FSM goes to IDLE next edge and st/idx clear to 0. No out_valid is produced.
//   abort has priority over a same-cycle accept or take.
//  Reset (async, any time, including mid-RUN): FSM = IDLE, st = 0, idx = 0.
//   Outputs after reset: in_ready 1, out_valid 0, busy 0, x*_o 0.
//  idx arithmetic is 5-bit internally, so idx + UNROLL never wraps.
// TESTING
//  - UNROLL=4, nr=12, state {0,0,0,0,0}: out_valid exactly 3 edges after accept; x*_o equals the C reference p12.
//  - UNROLL=4, nr=6, random state: 2 cycles; trace shows constants 96,87,78,69 then 5a,4b with slots 2..3 bypassed.
//  - nr=1: 1 cycle, only constant 4b applied. nr=0: 1 cycle, x*_o equals x*_i bit-exact.
//  - out_ready held 0 for 10 cycles in DONE: x*_o stable, in_ready 0, a second in_valid is not accepted.
//  - abort asserted in 2nd RUN cycle of nr=12 (UNROLL=1): IDLE next edge, out_valid never rises, next request correct.
//  - rst_n pulsed low mid-RUN: all outputs 0 / in_ready 1 immediately. Sweep UNROLL in {1,2,3,6,12} against the model.

Source files
------------

// File: rtl/ascon_perm_engine.sv
// Handshaked Ascon permutation p^nr engine: UNROLL rounds per cycle on a 320-bit state,
// with backpressure on the result and a synchronous abort that flushes the engine.
module ascon_perm_engine #(
    parameter int UNROLL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  nr,
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o,
    input  logic        abort,
    output logic        busy
);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 ||
              UNROLL == 4 || UNROLL == 6 || UNROLL == 12)) begin : g_bad_unroll
            $error("ascon_perm_engine: UNROLL must be one of 1,2,3,4,6,12");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [4:0] STEP = 5'(UNROLL);

    state_t       r_state, w_next;
    logic [319:0] r_st;
    logic [4:0]   r_idx;
    logic [319:0] w_chain_in, w_chain_out;
    logic [4:0]   w_idx0, w_base, w_idx_nxt;
    logic [3:0]   w_nr;
    logic         w_last, w_accept;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] a0, a1, a2, a3, a4;
        logic [63:0] t0, t1, t2, t3, t4;
        {a0, a1, a2, a3, a4} = s;
        a2 = a2 ^ {56'h0, ~r, r};
        a0 = a0 ^ a4;  a4 = a4 ^ a3;  a2 = a2 ^ a1;
        t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
        a0 = a0 ^ t1;  a1 = a1 ^ t2;  a2 = a2 ^ t3;  a3 = a3 ^ t4;  a4 = a4 ^ t0;
        a1 = a1 ^ a0;  a0 = a0 ^ a4;  a3 = a3 ^ a2;  a2 = ~a2;
        a0 = a0 ^ ror(a0, 19) ^ ror(a0, 28);
        a1 = a1 ^ ror(a1, 61) ^ ror(a1, 39);
        a2 = a2 ^ ror(a2, 1)  ^ ror(a2, 6);
        a3 = a3 ^ ror(a3, 10) ^ ror(a3, 17);
        a4 = a4 ^ ror(a4, 7)  ^ ror(a4, 41);
        return {a0, a1, a2, a3, a4};
    endfunction

    // nr = 0 gives idx0 = 12, so every slot is bypassed and the state passes through untouched
    assign w_nr       = (nr > 4'd12) ? 4'd12 : nr;
    assign w_idx0     = 5'd12 - {1'b0, w_nr};
    assign w_base     = (r_state == S_IDLE) ? w_idx0 : r_idx;
    assign w_chain_in = (r_state == S_IDLE) ? {x0_i, x1_i, x2_i, x3_i, x4_i} : r_st;
    assign w_idx_nxt  = w_base + STEP;
    assign w_last     = (w_idx_nxt >= 5'd12);
    assign w_accept   = (r_state == S_IDLE) && in_valid && !abort;

    always_comb begin
        w_chain_out = w_chain_in;
        for (int j = 0; j < UNROLL; j++) begin
            if (w_base + 5'(j) <= 5'd11)
                w_chain_out = ascon_round(w_chain_out, 4'(w_base + 5'(j)));
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid)  w_next = w_last ? S_DONE : S_RUN;
                S_RUN:   if (w_last)    w_next = S_DONE;
                S_DONE:  if (out_ready) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st  <= '0;
            r_idx <= '0;
        end else if (abort) begin
            r_st  <= '0;
            r_idx <= '0;
        end else if (w_accept || r_state == S_RUN) begin
            r_st  <= w_chain_out;
            r_idx <= w_idx_nxt;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign {x0_o, x1_o, x2_o, x3_o, x4_o} = out_valid ? r_st : 320'h0;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Bench for ascon_perm_engine: six instances (UNROLL 1,2,3,4,6,12) share stimulus and are
// checked against a table-driven Ascon reference model for data, latency and handshakes.
module tb_ascon_perm_engine;

    localparam int NI = 6;

    function automatic int ul(input int k);
        case (k)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            4: return 6;
            default: return 12;
        endcase
    endfunction

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    logic        clk, rst_n, in_valid, out_ready, abort;
    logic [3:0]  nr;
    logic [63:0] xi0, xi1, xi2, xi3, xi4;
    logic        ir [NI];
    logic        ov [NI];
    logic        bz [NI];
    logic [63:0] o0 [NI];
    logic [63:0] o1 [NI];
    logic [63:0] o2 [NI];
    logic [63:0] o3 [NI];
    logic [63:0] o4 [NI];

    int total = 0;
    int bad   = 0;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        ascon_perm_engine #(.UNROLL(ul(k))) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid), .in_ready(ir[k]), .nr(nr),
            .x0_i(xi0), .x1_i(xi1), .x2_i(xi2), .x3_i(xi3), .x4_i(xi4),
            .out_valid(ov[k]), .out_ready(out_ready),
            .x0_o(o0[k]), .x1_o(o1[k]), .x2_o(o2[k]), .x3_o(o3[k]), .x4_o(o4[k]),
            .abort(abort), .busy(bz[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Linear layer on one word: bit i collects bits i, i+a, i+b (rotate-right XOR)
    function automatic logic [63:0] mix(input logic [63:0] x, input int a, input int b);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[i] = x[i] ^ x[(i + a) % 64] ^ x[(i + b) % 64];
        return y;
    endfunction

    function automatic logic [319:0] model(input logic [319:0] s, input int nreq);
        logic [63:0] x [5];
        logic [4:0]  v, o;
        int n;
        n = (nreq > 12) ? 12 : nreq;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64 * i -: 64];
        for (int r = 12 - n; r < 12; r++) begin
            x[2] = x[2] ^ 64'(240 - 15 * r);
            for (int b = 0; b < 64; b++) begin
                v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o = SBOX[v];
                x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
            end
            x[0] = mix(x[0], 19, 28);
            x[1] = mix(x[1], 61, 39);
            x[2] = mix(x[2], 1, 6);
            x[3] = mix(x[3], 10, 17);
            x[4] = mix(x[4], 7, 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic int lat_exp(input int nreq, input int k);
        int n, l;
        n = (nreq > 12) ? 12 : nreq;
        l = (n + ul(k) - 1) / ul(k);
        return (l < 1) ? 1 : l;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32 * i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [319:0] outs(input int k);
        return {o0[k], o1[k], o2[k], o3[k], o4[k]};
    endfunction

    task automatic chk(input string tag, input int k, input logic [319:0] obs, input logic [319:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s u=%0d observed=%h expected=%h", tag, ul(k), obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] nv, input logic [319:0] sv);
        nr = nv;
        {xi0, xi1, xi2, xi3, xi4} = sv;
    endtask

    task automatic check_idle(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk({tag, "_in_ready"}, k, 320'(ir[k]), 320'(1));
            chk({tag, "_out_valid"}, k, 320'(ov[k]), 320'(0));
            chk({tag, "_busy"}, k, 320'(bz[k]), 320'(0));
            chk({tag, "_x_o"}, k, outs(k), 320'h0);
        end
    endtask

    task automatic run_req(input logic [3:0] nv, input logic [319:0] sv, input bit hold);
        logic [319:0] exp;
        bit got [NI];
        bit all;
        exp = model(sv, int'(nv));
        for (int k = 0; k < NI; k++) got[k] = 1'b0;
        set_in(nv, sv);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        set_in(4'($urandom), rand320());
        for (int c = 1; c <= 16; c++) begin
            all = 1'b1;
            for (int k = 0; k < NI; k++) begin
                if (ov[k] && !got[k]) begin
                    got[k] = 1'b1;
                    chk("latency", k, 320'(c), 320'(lat_exp(int'(nv), k)));
                    chk("result", k, outs(k), exp);
                end
                all = all & got[k];
            end
            if (all) break;
            step();
        end
        for (int k = 0; k < NI; k++) chk("result_seen", k, 320'(got[k]), 320'(1));
        if (hold) begin
            in_valid = 1'b1;
            for (int c = 0; c < 10; c++) begin
                set_in(4'($urandom), rand320());
                step();
                for (int k = 0; k < NI; k++) begin
                    chk("hold_x_o", k, outs(k), exp);
                    chk("hold_out_valid", k, 320'(ov[k]), 320'(1));
                    chk("hold_in_ready", k, 320'(ir[k]), 320'(0));
                end
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_idle("after_take");
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        set_in(4'd0, 320'h0);
        step();
        step();
        check_idle("reset");
        rst_n = 1'b1;
        step();

        run_req(4'd12, 320'h0, 1'b0);
        run_req(4'd6, rand320(), 1'b0);
        run_req(4'd1, rand320(), 1'b0);
        run_req(4'd0, rand320(), 1'b0);
        run_req(4'd15, rand320(), 1'b0);
        run_req(4'd8, rand320(), 1'b1);

        // Abort during the second RUN cycle of a 12-round request
        set_in(4'd12, rand320());
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        abort = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check_idle("abort");
        for (int c = 0; c < 14; c++) begin
            step();
            for (int k = 0; k < NI; k++) chk("abort_no_valid", k, 320'(ov[k]), 320'(0));
        end
        abort = 1'b1; in_valid = 1'b1;
        step();
        abort = 1'b0; in_valid = 1'b0;
        check_idle("abort_vs_accept");
        run_req(4'd12, rand320(), 1'b0);

        // Asynchronous reset in the middle of a run
        set_in(4'd12, rand320());
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1 check_idle("reset_mid_run");
        #1 rst_n = 1'b1;
        run_req(4'd12, rand320(), 1'b0);

        for (int t = 0; t < 8; t++) run_req(4'($urandom_range(0, 15)), rand320(), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
